// File: rtl/psum_accumulator.sv
// Read-modify-write controller for Port A of the partial-sum BRAM.
// Each item is either written directly (first pass) or added to the stored value.
module psum_accumulator #(
    parameter int unsigned BW = 32,
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 16
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [AW-1:0] IN_ADDR,
    input  logic [DW-1:0] IN_DATA,
    input  logic          IN_FIRST,
    input  logic          IN_LAST,
    output logic          EN_A,
    output logic          WE_A,
    output logic [AW-1:0] ADDR_A,
    output logic [BW-1:0] DIN_A,
    input  logic [BW-1:0] DOUT_A,
    output logic          BUSY,
    output logic          DONE,
    output logic [CW-1:0] WR_CNT
);

    typedef enum logic [1:0] {StIdle, StRd, StSum, StWr} state_e;

    state_e        state_q, state_d;
    logic          accept;
    logic [BW-1:0] ext;
    logic [BW-1:0] ext_q, ext_d;
    logic          last_q, last_d;
    logic          en_a_q, en_a_d;
    logic          we_a_q, we_a_d;
    logic [AW-1:0] addr_a_q, addr_a_d;
    logic [BW-1:0] din_a_q, din_a_d;
    logic          done_q, done_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;

    assign IN_READY = (state_q == StIdle) || (state_q == StWr);
    assign accept   = IN_VALID & IN_READY;
    assign ext      = BW'(signed'(IN_DATA));

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StWr: begin
                if (accept) begin
                    state_d = IN_FIRST ? StWr : StRd;
                end else begin
                    state_d = StIdle;
                end
            end
            StRd:    state_d = StSum;
            StSum:   state_d = StWr;
            default: state_d = StIdle;
        endcase
    end

    // Every WR cycle is left at the next edge, so each one is a completed write.
    always_comb begin
        en_a_d   = 1'b0;
        we_a_d   = we_a_q;
        addr_a_d = addr_a_q;
        din_a_d  = din_a_q;
        ext_d    = ext_q;
        last_d   = last_q;
        done_d   = (state_q == StWr) && last_q;
        wr_cnt_d = (state_q == StWr) ? wr_cnt_q + CW'(1) : wr_cnt_q;
        if (accept) begin
            en_a_d   = 1'b1;
            we_a_d   = IN_FIRST;
            addr_a_d = IN_ADDR;
            ext_d    = ext;
            last_d   = IN_LAST;
            if (IN_FIRST) begin
                din_a_d = ext;
            end
        end else if (state_q == StSum) begin
            en_a_d  = 1'b1;
            we_a_d  = 1'b1;
            din_a_d = DOUT_A + ext_q;
        end else if (state_q == StWr) begin
            we_a_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            en_a_q   <= 1'b0;
            we_a_q   <= 1'b0;
            addr_a_q <= '0;
            din_a_q  <= '0;
            ext_q    <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_cnt_q <= '0;
        end else begin
            en_a_q   <= en_a_d;
            we_a_q   <= we_a_d;
            addr_a_q <= addr_a_d;
            din_a_q  <= din_a_d;
            ext_q    <= ext_d;
            last_q   <= last_d;
            done_q   <= done_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign EN_A   = en_a_q;
    assign WE_A   = we_a_q;
    assign ADDR_A = addr_a_q;
    assign DIN_A  = din_a_q;
    assign BUSY   = (state_q != StIdle);
    assign DONE   = done_q;
    assign WR_CNT = wr_cnt_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with a read-first BRAM model on Port A.
module tb_psum_accumulator;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [9:0]  IN_ADDR;
    logic [15:0] IN_DATA;
    logic        IN_FIRST;
    logic        IN_LAST;
    logic        EN_A;
    logic        WE_A;
    logic [9:0]  ADDR_A;
    logic [31:0] DIN_A;
    logic [31:0] DOUT_A;
    logic        BUSY;
    logic        DONE;
    logic [15:0] WR_CNT;

    logic [31:0] mem [0:1023];
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] acc_vals [3] = '{16'd1, 16'd2, 16'hFFFC};
    logic [31:0] acc_exps [3] = '{32'd101, 32'd103, 32'd99};

    always #5 CLK = ~CLK;

    // Backdoor preload takes priority; otherwise a read-first single port.
    always @(posedge CLK) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (EN_A) begin
            if (WE_A) mem[ADDR_A] <= DIN_A;
            DOUT_A <= mem[ADDR_A];
        end
    end

    psum_accumulator #(
        .BW(32),
        .AW(10),
        .DW(16),
        .CW(16)
    ) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .IN_ADDR (IN_ADDR),
        .IN_DATA (IN_DATA),
        .IN_FIRST(IN_FIRST),
        .IN_LAST (IN_LAST),
        .EN_A    (EN_A),
        .WE_A    (WE_A),
        .ADDR_A  (ADDR_A),
        .DIN_A   (DIN_A),
        .DOUT_A  (DOUT_A),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .WR_CNT  (WR_CNT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [9:0] a, input logic [15:0] d, input logic f,
                         input logic l);
        IN_VALID = 1'b1;
        IN_ADDR  = a;
        IN_DATA  = d;
        IN_FIRST = f;
        IN_LAST  = l;
    endtask

    task automatic backdoor(input logic [9:0] a, input logic [31:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    // Accumulate item from IDLE: accept, RD, SUM, WR, back to IDLE.
    task automatic run_acc(input logic [9:0] a, input logic [15:0] d);
        drive(a, d, 1'b0, 1'b0);
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        tick();
    endtask

    function automatic logic [31:0] sx(input logic [15:0] d);
        return {{16{d[15]}}, d};
    endfunction

    initial begin
        logic [15:0] sd;
        RSTN = 1'b0; IN_VALID = 1'b0; IN_ADDR = '0; IN_DATA = '0;
        IN_FIRST = 1'b0; IN_LAST = 1'b0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        tick();
        tick();
        check("rst_ready", 32'(IN_READY), 32'd1);
        check("rst_en", 32'(EN_A), 32'd0);
        check("rst_we", 32'(WE_A), 32'd0);
        check("rst_addr", 32'(ADDR_A), 32'd0);
        check("rst_din", DIN_A, 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_cnt", 32'(WR_CNT), 32'd0);
        RSTN = 1'b1;
        tick();

        // Overwrite then accumulate at address 5
        drive(10'd5, 16'd7, 1'b1, 1'b0);
        tick();
        check("ow_busy", 32'(BUSY), 32'd1);
        check("ow_enwe", 32'(EN_A & WE_A), 32'd1);
        check("ow_din", DIN_A, 32'd7);
        drive(10'd5, 16'd3, 1'b0, 1'b0);
        tick();
        IN_VALID = 1'b0;
        check("acc_rd_ready", 32'(IN_READY), 32'd0);
        check("acc_rd_en", 32'(EN_A), 32'd1);
        check("acc_rd_we", 32'(WE_A), 32'd0);
        check("acc_rd_cnt", 32'(WR_CNT), 32'd1);
        tick();
        check("acc_sum_en", 32'(EN_A), 32'd0);
        tick();
        check("acc_wr_enwe", 32'(EN_A & WE_A), 32'd1);
        check("acc_wr_din", DIN_A, 32'd10);
        check("acc_wr_addr", 32'(ADDR_A), 32'd5);
        tick();
        check("acc_mem5", mem[5], 32'd10);
        check("acc_cnt", 32'(WR_CNT), 32'd2);
        check("acc_idle", 32'(BUSY), 32'd0);

        // Back-to-back accumulates to address 9 over a stored 100
        drive(10'd9, 16'd100, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(10'd9, acc_vals[i], 1'b0, 1'b0);
            tick();
            check("b2b_rd_ready", 32'(IN_READY), 32'd0);
            check("b2b_rd_wr", 32'(EN_A & WE_A), 32'd0);
            tick();
            check("b2b_sum_ready", 32'(IN_READY), 32'd0);
            check("b2b_sum_wr", 32'(EN_A & WE_A), 32'd0);
            tick();
            check("b2b_wr_ready", 32'(IN_READY), 32'd1);
            check("b2b_wr_enwe", 32'(EN_A & WE_A), 32'd1);
            check("b2b_wr_din", DIN_A, acc_exps[i]);
        end
        IN_VALID = 1'b0;
        tick();
        check("b2b_mem9", mem[9], 32'd99);
        check("b2b_cnt", 32'(WR_CNT), 32'd6);

        // Streaming first items, one accept per cycle
        sd = 16'h9000;
        drive(10'd0, sd, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("str_ready", 32'(IN_READY), 32'd1);
            check("str_enwe", 32'(EN_A & WE_A), 32'd1);
            check("str_addr", 32'(ADDR_A), 32'(i));
            check("str_din", DIN_A, sx(sd));
            sd = sd + 16'h1111;
            if (i < 7) drive(10'(i + 1), sd, 1'b1, 1'b0);
            else IN_VALID = 1'b0;
        end
        tick();
        sd = 16'h9000;
        for (int i = 0; i < 8; i++) begin
            check("str_mem", mem[i], sx(sd));
            sd = sd + 16'h1111;
        end
        check("str_cnt", 32'(WR_CNT), 32'd14);
        check("str_idle", 32'(BUSY), 32'd0);

        // Wraparound and negative sign extension
        backdoor(10'd20, 32'h7FFF_FFFF);
        backdoor(10'd21, 32'h0000_0000);
        run_acc(10'd20, 16'h0001);
        check("wrap_pos", mem[20], 32'h8000_0000);
        run_acc(10'd21, 16'h8000);
        check("wrap_neg", mem[21], 32'hFFFF_8000);
        check("wrap_cnt", 32'(WR_CNT), 32'd16);

        // LAST accumulate with a new item accepted in its WR cycle
        backdoor(10'd30, 32'd10);
        drive(10'd30, 16'd5, 1'b0, 1'b1);
        tick();
        drive(10'd31, 16'd2, 1'b1, 1'b0);
        check("last_rd_done", 32'(DONE), 32'd0);
        tick();
        check("last_sum_done", 32'(DONE), 32'd0);
        tick();
        check("last_wr_done", 32'(DONE), 32'd0);
        check("last_wr_ready", 32'(IN_READY), 32'd1);
        tick();
        check("last_done_hi", 32'(DONE), 32'd1);
        IN_VALID = 1'b0;
        tick();
        check("last_done_lo", 32'(DONE), 32'd0);
        check("last_mem30", mem[30], 32'd15);
        check("last_mem31", mem[31], 32'd2);
        check("last_cnt", 32'(WR_CNT), 32'd18);

        // FIRST and LAST on the same item
        drive(10'd40, 16'hFFFF, 1'b1, 1'b1);
        tick();
        check("fl_wr_done", 32'(DONE), 32'd0);
        IN_VALID = 1'b0;
        tick();
        check("fl_done_hi", 32'(DONE), 32'd1);
        check("fl_mem40", mem[40], 32'hFFFF_FFFF);
        tick();
        check("fl_done_lo", 32'(DONE), 32'd0);
        check("fl_cnt", 32'(WR_CNT), 32'd19);

        // Reset while SUM is in flight
        backdoor(10'd50, 32'd77);
        drive(10'd50, 16'd1, 1'b0, 1'b1);
        tick();
        IN_VALID = 1'b0;
        tick();
        check("mr_sum_busy", 32'(BUSY), 32'd1);
        check("mr_sum_ready", 32'(IN_READY), 32'd0);
        RSTN = 1'b0;
        tick();
        check("mr_busy", 32'(BUSY), 32'd0);
        check("mr_ready", 32'(IN_READY), 32'd1);
        check("mr_en", 32'(EN_A), 32'd0);
        check("mr_we", 32'(WE_A), 32'd0);
        check("mr_addr", 32'(ADDR_A), 32'd0);
        check("mr_din", DIN_A, 32'd0);
        check("mr_done", 32'(DONE), 32'd0);
        check("mr_cnt", 32'(WR_CNT), 32'd0);
        RSTN = 1'b1;
        tick();
        check("mr_done1", 32'(DONE), 32'd0);
        tick();
        check("mr_done2", 32'(DONE), 32'd0);
        check("mr_mem50", mem[50], 32'd77);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Read-modify-write controller that owns Port A of the partial-sum output BRAM (`BRAM_TDP`). It accepts a valid/ready stream of signed partial products tagged with an output address, adds each one to the value already stored at that address, and writes the sum back. A first-pass flag overwrites the stored value instead of adding to it. A last flag raises a done pulse, after which the PS reads the finished results through Port B.

## Interface
Parameters:
- `BW`, 32: partial-sum width; must match the BRAM data width.
- `AW`, 10: BRAM address width.
- `DW`, 16: incoming partial-product width, signed, `DW <= BW`.
- `CW`, 16: width of the write counter.

Ports:
- `CLK` in 1: the only clock; everything is on its rising edge.
- `RSTN` in 1: synchronous, active-low reset.
- `IN_VALID` in 1: input item valid.
- `IN_READY` out 1: controller can accept an item this cycle.
- `IN_ADDR` in AW: target BRAM address.
- `IN_DATA` in DW: signed partial product.
- `IN_FIRST` in 1: overwrite the stored value instead of accumulating.
- `IN_LAST` in 1: final item of the layer.
- `EN_A` out 1: BRAM Port A chip enable (registered).
- `WE_A` out 1: BRAM Port A write enable (registered).
- `ADDR_A` out AW: BRAM Port A address (registered).
- `DIN_A` out BW: BRAM Port A write data (registered).
- `DOUT_A` in BW: BRAM Port A read data; valid in the cycle after the read cycle.
- `BUSY` out 1: state is not IDLE.
- `DONE` out 1: one-cycle pulse after the write of a LAST item.
- `WR_CNT` out CW: number of completed writes.

## Operation
- An item is accepted when `IN_VALID & IN_READY`. At that edge the controller latches the address, the sign-extended data (`ext`), and the LAST flag.
- `IN_READY` is high exactly in the IDLE and WR states.
- States:
  - IDLE: nothing in flight.
  - RD: read issued to the BRAM.
  - SUM: read data on `DOUT_A`.
  - WR: write issued to the BRAM.
- Transitions on an accept, from IDLE or WR:
  - `IN_FIRST=1`: go to WR; register `EN_A=1`, `WE_A=1`, `ADDR_A=IN_ADDR`, `DIN_A=ext`.
  - `IN_FIRST=0`: go to RD; register `EN_A=1`, `WE_A=0`, `ADDR_A=IN_ADDR`.
- RD → SUM unconditionally; register `EN_A=0`.
- SUM → WR; register `EN_A=1`, `WE_A=1`, `DIN_A = DOUT_A + ext`. `ADDR_A` holds.
- WR with no accept → IDLE; register `EN_A=0`, `WE_A=0`.
- Leaving WR, whether to IDLE or to a new item, counts as a completed write:
  - `WR_CNT` increments and wraps modulo 2^CW.
  - If the written item was LAST, `DONE=1` in the next cycle only.
- Arithmetic: `ext` is `IN_DATA` sign-extended to BW. The sum wraps modulo 2^BW with no saturation.
- `DIN_A`, `ADDR_A` and `WE_A` hold their last values while `EN_A=0`. Only `EN_A` gates the BRAM.
- The controller never issues a read and a write in the same cycle; Port A is single-access.
- There is no read-after-write hazard. A write in WR lands at the WR-exit edge, and a following read to the same address is issued one cycle later.

## Timing
- Reset values: state IDLE, `IN_READY=1`, `EN_A=0`, `WE_A=0`, `ADDR_A=0`, `DIN_A=0`, `BUSY=0`, `DONE=0`, `WR_CNT=0`.
- Accumulate item accepted in cycle t:
  - RD in t+1.
  - SUM in t+2; `DOUT_A` is valid here.
  - WR in t+3; the memory is updated at the end of t+3.
  - Throughput is one item per 3 cycles, because the next item can be accepted in the WR cycle.
- First item accepted in cycle t: WR in t+1, memory updated at the end of t+1. Back-to-back first items sustain 1 item per cycle.
- DONE is high in cycle w+1, where w is the WR cycle of the LAST item. It is high regardless of whether a new item is accepted in w.
- Holding `IN_VALID` without `IN_READY`: inputs must stay stable. The controller samples them only on accept.
- Reset mid-operation (`RSTN=0` at an edge):
  - All registers take their reset values at that edge.
  - A write already presented in the WR cycle is still committed by the BRAM at that edge.
  - DONE is suppressed and `WR_CNT` does not count that write.
  - An in-flight RD or SUM is abandoned with no write.
- `IN_FIRST` and `IN_LAST` may both be set on the same item.

## Test plan
- **Overwrite then accumulate:** first item (addr 5, +7), then accumulate (addr 5, +3) → BRAM[5]=10; the accumulate's write `EN_A` is high 3 cycles after its accept; `WR_CNT=2`.
- **Back-to-back same address:** three accumulate items to addr 9 (+1, +2, −4), presented continuously, BRAM[9] pre-written 100 → final BRAM[9]=99; `IN_READY` is high only in IDLE and WR; `EN_A&WE_A` is never asserted in RD or SUM.
- **Streaming first items:** 8 consecutive first items to addresses 0..7 with `IN_VALID` held high → one accept per cycle, BRAM[i]=data[i], `WR_CNT=8`.
- **Negative and wrap:** `DW=16`, stored 0x7FFFFFFF + 0x0001 → 0x80000000; stored 0 + 0x8000 → 0xFFFF8000.
- **LAST/DONE:** an accumulate item with `IN_LAST=1` → DONE is high exactly one cycle, the cycle after its WR cycle; a new item accepted in that WR cycle does not suppress DONE.
- **Reset mid-read:** `RSTN` low during SUM → no write to the target address, all outputs at reset values the next cycle, DONE never pulses.
